// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit holding the HI/LO registers
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic               is_div_q, neg_res_q, neg_rem_q;
    logic               busy_q, done_q, dbz_q;

    logic               op_arith, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign op_arith  = (op_i <= 3'd3);
    assign op_div    = (op_i == 3'd2) || (op_i == 3'd3);
    assign op_signed = (op_i == 3'd0) || (op_i == 3'd2);
    assign a_neg     = op_signed & a_i[WIDTH-1];
    assign b_neg     = op_signed & b_i[WIDTH-1];
    assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

    // acc_q holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
    logic [WIDTH:0] mul_sum, rem_sh, diff;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (diff[WIDTH])
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quot     = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            lo_d = neg_res_q ? (~quot + 1'b1) : quot;
            hi_d = neg_rem_q ? (~rem + 1'b1) : rem;
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (op_div && (b_i == '0)) begin
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                        end else if (op_arith) begin
                            acc_q     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                            opnd_q    <= op_div ? b_mag : a_mag;
                            is_div_q  <= op_div;
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= CALC;
                        end else if (op_i == 3'd4) begin
                            hi_q <= a_i;
                        end else if (op_i == 3'd5) begin
                            lo_q <= a_i;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1))
                        state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - table-driven scoreboard bench for mdu_iter
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, dbz;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dbz;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0, n_err = 0, n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("lo", {32'd0, lo}, {32'd0, e.lo});
                check("div_by_zero", {63'd0, dbz}, {63'd0, e.dbz});
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        bit seen = 0;
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.hi = eh; v.lo = el;
        vecs.push_back(v);
    endtask

    initial begin
        int          lat, bn, n0;
        logic [63:0] p, sa, sbv;
        logic signed [31:0] s_a, s_b;
        logic [31:0] ra, rb;
        exp_t        e;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, dbz}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        add_vec(3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        add_vec(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        add_vec(3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        add_vec(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        add_vec(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        add_vec(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        add_vec(3'd0, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9);
        add_vec(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        add_vec(3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF);
        add_vec(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        add_vec(3'd2, 32'd5,        32'd7,        32'h00000005, 32'h00000000);
        add_vec(3'd1, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom | 32'd1;
            if (rb == 32'hFFFFFFFF) rb = 32'd3;
            p = {32'd0, ra} * {32'd0, rb};
            add_vec(3'd1, ra, rb, p[63:32], p[31:0]);
            sa  = {{32{ra[31]}}, ra};
            sbv = {{32{rb[31]}}, rb};
            p = sa * sbv;
            add_vec(3'd0, ra, rb, p[63:32], p[31:0]);
            add_vec(3'd3, ra, rb, ra % rb, ra / rb);
            s_a = ra; s_b = rb;
            add_vec(3'd2, ra, rb, 32'(s_a % s_b), 32'(s_a / s_b));
        end

        foreach (vecs[i]) begin
            e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.dbz = 1'b0;
            sb.push_back(e);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bn);
            check("latency", 64'(lat), 64'd34);
            check("busy_cycles", 64'(bn), 64'd33);
        end

        @(negedge clk);
        issue(3'd4, 32'h12345678, 32'd0);
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        issue(3'd5, 32'h9ABCDEF0, 32'd0);
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h9ABCDEF0});
        check("mtlo_done", {63'd0, done}, 64'd0);
        e.hi = 32'h12345678; e.lo = 32'h9ABCDEF0; e.dbz = 1'b1;
        sb.push_back(e);
        issue(3'd2, 32'd5, 32'd0);
        wait_done(lat, bn);
        check("dbz_latency", 64'(lat), 64'd1);
        check("dbz_busy", 64'(bn), 64'd0);
        @(negedge clk);
        check("dbz_pulse_done", {63'd0, done}, 64'd0);
        check("dbz_pulse_flag", {63'd0, dbz}, 64'd0);
        check("dbz_pulse_busy", {63'd0, busy}, 64'd0);

        n0 = n_done;
        e.hi = 32'd0; e.lo = 32'h0000000C; e.dbz = 1'b0;
        sb.push_back(e);
        issue(3'd1, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hDEADBEEF; b = 32'd0;
        @(negedge clk);
        op = 3'd0; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn);
        repeat (40) @(negedge clk);
        check("ignored_done_count", 64'(n_done - n0), 64'd1);
        check("ignored_sb_empty", 64'(sb.size()), 64'd0);
        check("ignored_hi", {32'd0, hi}, 64'd0);

        issue(3'd3, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_hi", {32'd0, hi}, 64'd0);
        check("async_rst_lo", {32'd0, lo}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        e.hi = 32'd0; e.lo = 32'd3; e.dbz = 1'b0;
        sb.push_back(e);
        issue(3'd3, 32'd9, 32'd3);
        wait_done(lat, bn);
        check("post_rst_latency", 64'(lat), 64'd34);
        repeat (2) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
